// File: rtl/systolic_pkg.sv
// Shared systolic array types and default geometry.
// Drain FSM states live here so array and drain agree.
package systolic_pkg;

   localparam int SA_ROWS      = 64;
   localparam int SA_COLS      = 64;
   localparam int SA_OP_WIDTH  = 48;
   localparam int SA_OUT_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      STREAM
   } drain_state_t;

endpackage

// File: rtl/drain_elem_reduce.sv
// Narrows one accumulator element to the streamed width.
// DRAIN_SATURATE_EN selects signed saturation, otherwise truncation.
module drain_elem_reduce #(
   parameter int op_width  = 48,
   parameter int out_width = 32
) (
   input  logic [op_width-1:0]  elem_in,
   output logic [out_width-1:0] elem_out
);

`ifdef DRAIN_SATURATE_EN
   localparam logic signed [op_width-1:0] SAT_MAX =
      {{(op_width-out_width+1){1'b0}}, {(out_width-1){1'b1}}};
   localparam logic signed [op_width-1:0] SAT_MIN =
      {{(op_width-out_width+1){1'b1}}, {(out_width-1){1'b0}}};

   always_comb begin
      elem_out = elem_in[out_width-1:0];
      if ($signed(elem_in) > SAT_MAX)
         elem_out = SAT_MAX[out_width-1:0];
      else if ($signed(elem_in) < SAT_MIN)
         elem_out = SAT_MIN[out_width-1:0];
   end
`else
   assign elem_out = elem_in[out_width-1:0];

   // Discarded high bits are intentionally dropped.
   if (op_width > out_width) begin : g_drop
      logic elem_unused;
      assign elem_unused = ^elem_in[op_width-1:out_width];
   end
`endif

endmodule

// File: rtl/systolic_output_drain.sv
// Captures a finished array result and streams it one row per beat.
// Element narrowing mode is set by the DRAIN_SATURATE_EN macro.
module systolic_output_drain
   import systolic_pkg::*;
#(
   parameter int rows      = SA_ROWS,
   parameter int cols      = SA_COLS,
   parameter int op_width  = SA_OP_WIDTH,
   parameter int out_width = SA_OUT_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          compute_done,
   input  logic [rows*cols*op_width-1:0] output_matrix,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [cols*out_width-1:0]     out_data,
   output logic [$clog2(rows)-1:0]       out_row,
   output logic                          out_last,
   output logic                          busy,
   output logic                          overrun,
   output logic [31:0]                   frame_count
);

   localparam int RW = $clog2(rows);
   localparam int BW = cols*op_width;
   localparam logic [RW-1:0] LAST_ROW = RW'(rows-1);

   drain_state_t state_q, state_d;

   logic          done_q;
   logic          rise;
   logic          fire;
   logic          at_last;
   logic [RW-1:0] row_q;
   logic [BW-1:0] frame_q [rows];
   logic [BW-1:0] row_bits;

   assign rise      = compute_done & ~done_q;
   assign out_valid = (state_q == STREAM);
   assign fire      = out_valid & out_ready;
   assign at_last   = (row_q == LAST_ROW);
   assign out_row   = row_q;
   assign out_last  = out_valid & at_last;
   assign busy      = (state_q != IDLE);
   assign row_bits  = frame_q[row_q];

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (rise) state_d = CAPTURE;
         CAPTURE: state_d = STREAM;
         STREAM:  if (fire && at_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         done_q      <= 1'b0;
         row_q       <= '0;
         overrun     <= 1'b0;
         frame_count <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= compute_done;
         // Edges outside IDLE, incl. the last-beat cycle, are lost.
         if (rise && state_q != IDLE)
            overrun <= 1'b1;
         if (fire) begin
            row_q <= at_last ? '0 : row_q + 1'b1;
            if (at_last)
               frame_count <= frame_count + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == CAPTURE)
         for (int r = 0; r < rows; r++)
            frame_q[r] <= output_matrix[r*BW +: BW];
   end

   for (genvar c = 0; c < cols; c++) begin : g_col
      drain_elem_reduce #(
         .op_width  (op_width),
         .out_width (out_width)
      ) u_reduce (
         .elem_in  (row_bits[c*op_width +: op_width]),
         .elem_out (out_data[c*out_width +: out_width])
      );
   end

endmodule

// File: doc/systolic_output_drain.md
SYSTOLIC_OUTPUT_DRAIN -- requirements
Module: systolic_output_drain

Interface
REQ-001 Parameter rows, default 64: array row count (number of beats per frame); SHALL be >= 2.
REQ-002 Parameter cols, default 64: array column count (elements per beat).
REQ-003 Parameter op_width, default 48: signed accumulator element width.
REQ-004 Parameter out_width, default 32: signed streamed element width; SHALL be <= op_width.
REQ-005 Port clk  input  1: single clock; all logic is rising-edge.
REQ-006 Port rst  input  1: reset, synchronous, active-high.
REQ-007 Port compute_done  input  1: array result-ready level; a rising edge marks a new frame.
REQ-008 Port output_matrix  input  rows*cols*op_width: flattened result; element (r,c) sits at bits [(r*cols+c)*op_width +: op_width].
REQ-009 Port out_valid  output  1: beat valid.
REQ-010 Port out_ready  input  1: downstream accept.
REQ-011 Port out_data  output  cols*out_width: row beat; column c sits at bits [c*out_width +: out_width].
REQ-012 Port out_row  output  $clog2(rows): row index of the current beat.
REQ-013 Port out_last  output  1: high on the row rows-1 beat.
REQ-014 Port busy  output  1: frame held or streaming.
REQ-015 Port overrun  output  1: sticky flag, a frame was dropped.
REQ-016 Port frame_count  output  32: count of completed frames; wraps modulo 2^32.

Function
REQ-017 The block SHALL detect the compute_done rising edge against a registered copy of compute_done.
REQ-018 FSM states SHALL be IDLE, CAPTURE and STREAM.
REQ-019 IDLE->CAPTURE on a rising edge; CAPTURE copies output_matrix into an internal frame buffer in one cycle; CAPTURE->STREAM unconditionally.
REQ-020 The first beat (row 0) SHALL present out_valid=1 in the cycle after CAPTURE, i.e. 2 cycles after the rising edge is sampled.
REQ-021 A beat SHALL transfer only when out_valid and out_ready are both high.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_row and out_last SHALL hold stable.
REQ-023 After a row-r transfer with r<rows-1, row r+1 SHALL be valid the next cycle; back-to-back transfers SHALL sustain 1 beat per cycle.
REQ-024 On the out_last transfer: STREAM->IDLE, out_valid=0 the next cycle, and frame_count increments.
REQ-025 A rising edge in CAPTURE or STREAM SHALL be dropped (buffer untouched) and SHALL set overrun; overrun clears only on rst.
REQ-026 A rising edge in the same cycle as the out_last transfer SHALL be dropped and SHALL set overrun.
REQ-027 busy SHALL be 1 exactly when the state is not IDLE.
REQ-028 Each element SHALL be reduced from op_width to out_width per REQ-031 and REQ-032; when out_width==op_width it SHALL pass unchanged.

Reset
REQ-029 While rst is high at a clock edge: state goes to IDLE; out_valid, out_row, out_last, busy, overrun and frame_count go to 0; the compute_done edge register goes to 0.
REQ-030 Reset mid-STREAM SHALL abandon the frame without a further beat; the frame buffer contents are don't-care.

Configuration
REQ-031 With DRAIN_SATURATE_EN defined, each element SHALL saturate to the signed out_width range [-2^(out_width-1), 2^(out_width-1)-1].
REQ-032 Without DRAIN_SATURATE_EN, each element SHALL be truncated to its low out_width bits.

Structure
REQ-033 Package systolic_pkg SHALL hold the drain_state_t enum (IDLE, CAPTURE, STREAM) and the default width constants shared with systolic_array.
REQ-034 Element reduction SHALL be a sub-module, drain_elem_reduce (op_width in, out_width out), instantiated cols times.

Verification (rows=4, cols=4, op_width=48, out_width=32)
REQ-035 Ramp: element(r,c)=r*4+c, compute_done pulse, out_ready=1 -> 4 consecutive beats, rows 0..3, out_last on row 3, frame_count=1.
REQ-036 Backpressure: out_ready toggled 1,0,0,1,... -> beats appear in order, data stable while stalled, no beat lost or duplicated.
REQ-037 Overrun: second compute_done edge during beat 1 -> first frame completes intact, overrun=1, frame_count=1.
REQ-038 Reduction: element=48'h0000_8000_0000 -> 32'h7FFF_FFFF with DRAIN_SATURATE_EN, 32'h8000_0000 without; element=-5 -> 32'hFFFF_FFFB in both builds.
REQ-039 Reset mid-STREAM after beat 1 -> out_valid=0, busy=0, frame_count=0 next cycle; a new edge afterwards streams rows 0..3 normally.
REQ-040 compute_done held high for 10 cycles -> exactly one frame, overrun stays 0.
